box_plotter_param: RTL



---
 rtl/box_plotter_param.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/box_plotter_param.sv
// Box plotter: loads X, then Y and colour, through key press/release handshakes, then streams
// a clipped BOX_W x BOX_H rectangle or a full-screen clear, one pixel per clock.
module box_plotter_param #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int X_BITS          = 8,
    parameter int Y_BITS          = 7,
    parameter int COLOUR_BITS     = 3,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4
) (
    input  logic                   iClock,
    input  logic                   iResetn,
    input  logic                   iLoadX,
    input  logic                   iPlotBox,
    input  logic                   iBlack,
    input  logic [COLOUR_BITS-1:0] iColour,
    input  logic [X_BITS-1:0]      iXY_Coord,
    output logic [X_BITS-1:0]      oX,
    output logic [Y_BITS-1:0]      oY,
    output logic [COLOUR_BITS-1:0] oColour,
    output logic                   oPlot,
    output logic                   oBusy,
    output logic                   oDone
);

    // The counters are shared by box drawing and clearing, so they span the larger extent.
    localparam int CX_MAX = (BOX_W > X_SCREEN_PIXELS) ? BOX_W : X_SCREEN_PIXELS;
    localparam int CY_MAX = (BOX_H > Y_SCREEN_PIXELS) ? BOX_H : Y_SCREEN_PIXELS;
    localparam int CX_W   = (CX_MAX > 1) ? $clog2(CX_MAX) : 1;
    localparam int CY_W   = (CY_MAX > 1) ? $clog2(CY_MAX) : 1;
    localparam int SX_W   = ((X_BITS > CX_W) ? X_BITS : CX_W) + 1;
    localparam int SY_W   = ((Y_BITS > CY_W) ? Y_BITS : CY_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE_X,
        S_LOAD_X_WAIT,
        S_IDLE_Y,
        S_LOAD_Y_WAIT,
        S_DRAW,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [X_BITS-1:0]      r_baseX;
    logic [Y_BITS-1:0]      r_baseY;
    logic [COLOUR_BITS-1:0] r_colour;
    logic [CX_W-1:0]        r_cx;
    logic [CY_W-1:0]        r_cy;

    logic [SX_W-1:0] w_sumX;
    logic [SY_W-1:0] w_sumY;
    logic            w_onScreen;
    logic [CX_W-1:0] w_lastCx;
    logic [CY_W-1:0] w_lastCy;
    logic            w_rowEnd;
    logic            w_frameEnd;

    // Sums are one bit wider than the coordinates so off-screen pixels cannot wrap back on.
    assign w_sumX     = SX_W'(r_baseX) + SX_W'(r_cx);
    assign w_sumY     = SY_W'(r_baseY) + SY_W'(r_cy);
    assign w_onScreen = (w_sumX < SX_W'(X_SCREEN_PIXELS)) && (w_sumY < SY_W'(Y_SCREEN_PIXELS));
    assign w_lastCx   = (r_state == S_CLEAR) ? CX_W'(X_SCREEN_PIXELS - 1) : CX_W'(BOX_W - 1);
    assign w_lastCy   = (r_state == S_CLEAR) ? CY_W'(Y_SCREEN_PIXELS - 1) : CY_W'(BOX_H - 1);
    assign w_rowEnd   = (r_cx == w_lastCx);
    assign w_frameEnd = w_rowEnd && (r_cy == w_lastCy);

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_state  <= S_IDLE_X;
            r_baseX  <= '0;
            r_baseY  <= '0;
            r_colour <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            oX       <= '0;
            oY       <= '0;
            oColour  <= '0;
            oPlot    <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            oPlot <= 1'b0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
            case (r_state)
                S_IDLE_X: begin
                    if (iBlack) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_CLEAR;
                    end else if (iLoadX) begin
                        r_state <= S_LOAD_X_WAIT;
                    end
                end
                S_LOAD_X_WAIT: begin
                    if (iLoadX) r_baseX <= iXY_Coord;
                    else        r_state <= S_IDLE_Y;
                end
                S_IDLE_Y: begin
                    if (iBlack) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_CLEAR;
                    end else if (iPlotBox) begin
                        r_state <= S_LOAD_Y_WAIT;
                    end else if (iLoadX) begin
                        r_state <= S_LOAD_X_WAIT;
                    end
                end
                S_LOAD_Y_WAIT: begin
                    if (iPlotBox) begin
                        r_baseY  <= iXY_Coord[Y_BITS-1:0];
                        r_colour <= iColour;
                    end else begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW, S_CLEAR: begin
                    // Clipped pixels still take their cycle, keeping the draw length fixed.
                    if (r_state == S_DRAW) begin
                        oX      <= w_sumX[X_BITS-1:0];
                        oY      <= w_sumY[Y_BITS-1:0];
                        oColour <= r_colour;
                        oPlot   <= w_onScreen;
                    end else begin
                        oX      <= X_BITS'(r_cx);
                        oY      <= Y_BITS'(r_cy);
                        oColour <= '0;
                        oPlot   <= 1'b1;
                    end
                    oBusy <= 1'b1;
                    if (w_rowEnd) begin
                        r_cx <= '0;
                        if (w_frameEnd) r_state <= S_DONE;
                        else            r_cy    <= r_cy + CY_W'(1);
                    end else begin
                        r_cx <= r_cx + CX_W'(1);
                    end
                end
                S_DONE: begin
                    oDone   <= 1'b1;
                    r_state <= S_IDLE_X;
                end
                default: r_state <= S_IDLE_X;
            endcase
        end
    end

endmodule
